// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: shared state encoding, defaults and sizing helper for the layer sequencer.
package cnn_seq_pkg;
   localparam int DEF_NUM_STAGES     = 8;
   localparam int DEF_TIMEOUT_CYCLES = 65536;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LAUNCH = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_FINISH = 3'd3;
   localparam logic [2:0] ST_ERR    = 3'd4;
   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_LAUNCH = ST_LAUNCH,
      S_WAIT   = ST_WAIT,
      S_FINISH = ST_FINISH,
      S_ERR    = ST_ERR
   } seq_state_e;
   function automatic int idx_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/seq_next_stage.sv
// seq_next_stage: lowest available stage index at or above base, with a none flag.
import cnn_seq_pkg::*;
module seq_next_stage #(
   parameter  int N  = DEF_NUM_STAGES,
   localparam int SW = idx_width(N)
) (
   input  logic [N-1:0]  avail,
   input  logic [SW:0]   base,
   output logic [SW-1:0] idx,
   output logic          none
);
   always_comb begin
      idx  = '0;
      none = 1'b1;
      for (int i = N - 1; i >= 0; i--)
         if (avail[i] && i >= int'(base)) begin
            idx  = SW'(i);
            none = 1'b0;
         end
   end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: launches non-skipped CNN stages in order and waits for each done.
// Define LAYER_SEQ_WATCHDOG_EN to enable the per-stage busy watchdog (error/err_stage).
import cnn_seq_pkg::*;
module layer_sequencer #(
   parameter  int NUM_STAGES     = DEF_NUM_STAGES,
   parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int SW             = idx_width(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run_start,
   input  logic                  abort,
   input  logic [NUM_STAGES-1:0] skip_mask,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic [SW-1:0]         cur_stage,
   output logic                  busy,
   output logic                  run_done,
   output logic                  error,
   output logic [SW-1:0]         err_stage
);
   logic [2:0]            state, state_d;
   logic [NUM_STAGES-1:0] mask_q;
   logic [SW-1:0]         nx_idx;
   logic                  nx_none, idle, accept, done_hit, tmo;
   assign idle     = state == ST_IDLE;
   assign accept   = idle && run_start && !abort;
   assign done_hit = stage_done[cur_stage];
   // In IDLE search the incoming mask from 0; otherwise the latched mask above cur_stage.
   seq_next_stage #(.N(NUM_STAGES)) u_next (
      .avail (idle ? ~skip_mask : ~mask_q),
      .base  (idle ? '0 : (SW+1)'(cur_stage) + (SW+1)'(1)),
      .idx   (nx_idx),
      .none  (nx_none)
   );
   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE:   state_d = accept ? (nx_none ? ST_FINISH : ST_LAUNCH) : ST_IDLE;
         ST_LAUNCH: state_d = abort ? ST_IDLE : ST_WAIT;
         ST_WAIT:   state_d = abort ? ST_IDLE : done_hit ? (nx_none ? ST_FINISH : ST_LAUNCH) : tmo ? ST_ERR : ST_WAIT;
         default:   state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         run_done    <= 1'b0;
         stage_start <= '0;
         cur_stage   <= '0;
         mask_q      <= '0;
      end else begin
         state       <= state_d;
         busy        <= state_d != ST_IDLE;
         run_done    <= state_d == ST_FINISH;
         stage_start <= state_d == ST_LAUNCH ? NUM_STAGES'(1) << nx_idx : '0;
         if (state_d == ST_LAUNCH) cur_stage <= nx_idx;
         if (accept) mask_q <= skip_mask;
      end
`ifdef LAYER_SEQ_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt       <= '0;
         error     <= 1'b0;
         err_stage <= '0;
      end else begin
         if (state == ST_LAUNCH) cnt <= '0;
         else if (state == ST_WAIT) cnt <= cnt + CW'(1);
         if (accept) error <= 1'b0;
         else if (state_d == ST_ERR) begin
            error     <= 1'b1;
            err_stage <= cur_stage;
         end
      end
`else
   assign tmo       = 1'b0;
   assign error     = 1'b0;
   assign err_stage = '0;
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed checks of stage ordering, skip, abort, watchdog and reset.
module tb_layer_sequencer;
   logic       clk = 1'b0, rst_n = 1'b0, run_start = 1'b0, abort = 1'b0;
   logic [7:0] skip_mask = '0, stage_done = '0, stage_start;
   logic [2:0] cur_stage, err_stage;
   logic       busy, run_done, error;
   int         checks = 0, errors = 0;

   always #5 clk = ~clk;

   layer_sequencer #(.NUM_STAGES(8), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .run_start(run_start), .abort(abort),
      .skip_mask(skip_mask), .stage_done(stage_done), .stage_start(stage_start),
      .cur_stage(cur_stage), .busy(busy), .run_done(run_done),
      .error(error), .err_stage(err_stage)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One pass: each stage answers done 5 cycles after its start pulse.
   // inj: stage during whose wait a stray run_start and stage_done[6] are driven.
   // abort_at: stage whose done coincides with abort. hang_at: stage that never answers.
   task automatic run_pass(input logic [7:0] m, input int inj, input int abort_at, input int hang_at);
      int last = -1;
      skip_mask = m;
      run_start = 1'b1;
      step();
      run_start = 1'b0;
      skip_mask = ~m;
      if (m == 8'hFF) begin
         chk("allskip_run_done", run_done, 1);
         chk("allskip_no_start", stage_start, 0);
         chk("allskip_error_clr", error, 0);
         step();
         chk("allskip_run_done_low", run_done, 0);
         chk("allskip_idle", busy, 0);
         return;
      end
      for (int k = 0; k < 8; k++) begin
         if (m[k]) continue;
         last = k;
         chk($sformatf("start_%0d", k), stage_start, 32'd1 << k);
         chk($sformatf("cur_%0d", k), cur_stage, k);
         chk($sformatf("busy_%0d", k), busy, 1);
         if (k == hang_at) begin
`ifdef LAYER_SEQ_WATCHDOG_EN
            repeat (16) step();
            chk("wd_pre_error", error, 0);
            chk("wd_pre_busy", busy, 1);
            step();
            chk("wd_error", error, 1);
            chk("wd_err_stage", err_stage, k);
            step();
            chk("wd_busy_drop", busy, 0);
            chk("wd_error_held", error, 1);
`else
            repeat (30) step();
            chk("nowd_still_busy", busy, 1);
            chk("nowd_error", error, 0);
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("nowd_abort_idle", busy, 0);
`endif
            return;
         end
         for (int j = 0; j < 5; j++) begin
            if (k == inj && j == 2) begin
               run_start  = 1'b1;
               stage_done = 8'h40;
            end
            step();
            run_start  = 1'b0;
            stage_done = '0;
            chk($sformatf("gap_start_%0d_%0d", k, j), stage_start, 0);
            chk($sformatf("gap_done_%0d_%0d", k, j), run_done, 0);
         end
         stage_done = 8'(1) << k;
         if (k == abort_at) abort = 1'b1;
         step();
         stage_done = '0;
         abort = 1'b0;
         if (k == abort_at) begin
            chk("abort_no_start", stage_start, 0);
            chk("abort_no_done", run_done, 0);
            chk("abort_idle", busy, 0);
            chk("abort_error", error, 0);
            step();
            chk("abort_no_start2", stage_start, 0);
            chk("abort_no_done2", run_done, 0);
            return;
         end
      end
      chk("run_done", run_done, 1);
      chk("finish_no_start", stage_start, 0);
      chk("finish_busy", busy, 1);
      step();
      chk("run_done_low", run_done, 0);
      chk("idle_busy", busy, 0);
      chk("cur_hold", cur_stage, last);
   endtask

   initial begin
      logic seen;
      #12;
      chk("rst_start", stage_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_run_done", run_done, 0);
      chk("rst_error", error, 0);
      chk("rst_err_stage", err_stage, 0);
      chk("rst_cur", cur_stage, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      run_start = 1'b1;
      abort     = 1'b1;
      step();
      run_start = 1'b0;
      abort     = 1'b0;
      chk("abort_blocks_start", busy, 0);
      chk("abort_blocks_pulse", stage_start, 0);
      run_pass(8'h00, -1, -1, -1);
      run_pass(8'b0101_0110, -1, -1, -1);
      run_pass(8'hFF, -1, -1, -1);
      run_pass(8'h00, 3, -1, -1);
      run_pass(8'h00, -1, 4, -1);
      run_pass(8'h00, -1, -1, 2);
      run_pass(8'hFF, -1, -1, -1);
      skip_mask = 8'h00;
      run_start = 1'b1;
      step();
      run_start = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_cur", cur_stage, 0);
      chk("midrst_start", stage_start, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         seen = seen | run_done | (|stage_start) | busy;
      end
      chk("midrst_quiet", seen, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end
endmodule
